// File: rtl/cpu_pkg.sv
// Shared types and encodings for the ARM32 multi-cycle controller.
//   state_t      : sequencer state encoding
//   CLS_*        : iclass field values (instr[27:26])
//   OP_*         : opcodes with dedicated handling (HALT, branch family)
//   LDR_*/STR_*  : ld/st class nibbles carried in opcode[6:3]
//   COND_*       : ARM condition field encodings
//   PC_* / WB_*  : sel_pc and sel_wb source codes
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [1:0] CLS_DATA   = 2'b00;
  localparam logic [1:0] CLS_LDST   = 2'b01;
  localparam logic [1:0] CLS_BRANCH = 2'b10;

  localparam logic [6:0] OP_HALT = 7'b0000001;
  localparam logic [6:0] OP_B    = 7'b1000000;
  localparam logic [6:0] OP_BL   = 7'b1000001;
  localparam logic [6:0] OP_BX   = 7'b1000010;
  localparam logic [6:0] OP_BLX  = 7'b1000011;

  // ALU operation in opcode[2:0]; CMP only updates flags.
  localparam logic [2:0] ALU_CMP = 3'b010;

  // Ld/st class nibbles: 1100 LDR imm, 1101 LDR reg, 1110 STR imm, 1111 STR reg.
  localparam logic [3:0] LDR_IMM = 4'b1100;
  localparam logic [3:0] LDR_REG = 4'b1101;
  localparam logic [3:0] STR_REG = 4'b1111;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_RM     = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

endpackage

// File: rtl/cpu_controller_cond_check.sv
// cond_check: ARM condition-code evaluation, purely combinational.
//   cond  in  4  instruction condition field
//   nzcv  in  4  status flags {N,Z,C,V}
//   pass  out 1  instruction may execute (1111 never passes)
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n_s, z_s, c_s, v_s;

  assign n_s = nzcv[3];
  assign z_s = nzcv[2];
  assign c_s = nzcv[1];
  assign v_s = nzcv[0];

  // Condition table lookup
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z_s;
      COND_NE: pass = ~z_s;
      COND_CS: pass = c_s;
      COND_CC: pass = ~c_s;
      COND_MI: pass = n_s;
      COND_PL: pass = ~n_s;
      COND_VS: pass = v_s;
      COND_VC: pass = ~v_s;
      COND_HI: pass = c_s & ~z_s;
      COND_LS: pass = ~c_s | z_s;
      COND_GE: pass = (n_s == v_s);
      COND_LT: pass = (n_s != v_s);
      COND_GT: pass = ~z_s & (n_s == v_s);
      COND_LE: pass = z_s | (n_s != v_s);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: multi-cycle FETCH-DECODE-EXEC-MEM-WB sequencer for the ARM32 datapath.
// Inputs : clk, rst_n (async active-low), start, cond/opcode/iclass/en_status from the
//          decoder, nzcv flags, imem_ready, dmem_ready.
// Outputs: memory requests (imem_req, dmem_req, dmem_we), datapath enables (load_ir, load_pc,
//          sel_pc, load_abc, sel_a_imm, alu_go, load_status, rf_we, sel_wb), halted, fault.
// Outputs are decoded from the state register (plus ready for load_ir/load_pc), so an async
// reset drops the memory requests without waiting for a clock edge.
// Optional macro CPU_PERF_CNT_EN adds cyc_cnt/ret_cnt performance counters.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  cond,
  input  logic [6:0]  opcode,
  input  logic [1:0]  iclass,
  input  logic        en_status,
  input  logic [3:0]  nzcv,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        load_ir,
  output logic        load_pc,
  output logic [1:0]  sel_pc,
  output logic        load_abc,
  output logic        sel_a_imm,
  output logic        alu_go,
  output logic        load_status,
  output logic        rf_we,
  output logic [1:0]  sel_wb,
  output logic        halted,
  output logic        fault
`ifdef CPU_PERF_CNT_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] ret_cnt
`endif
);

  localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 32'd1);

  state_t      state_r, state_s;
  logic [15:0] tmo_cnt_r;
  logic        cond_pass_s;
  logic        tmo_hit_s;
  logic        is_ldr_s;
  logic        ldst_reg_s;

  cond_check u_cond_check (
    .cond (cond),
    .nzcv (nzcv),
    .pass (cond_pass_s)
  );

  assign is_ldr_s   = (opcode[6:3] == LDR_IMM) || (opcode[6:3] == LDR_REG);
  assign ldst_reg_s = (opcode[6:3] == LDR_REG) || (opcode[6:3] == STR_REG);
  // Counter holds the number of wait cycles already spent in FETCH/MEM.
  assign tmo_hit_s  = (MEM_TIMEOUT != 32'd0) && (tmo_cnt_r == TMO_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Memory wait counter: cleared on every state change, counts while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_r <= 16'd0;
    end else if (state_s != state_r) begin
      tmo_cnt_r <= 16'd0;
    end else if (((state_r == S_FETCH) || (state_r == S_MEM)) && (tmo_cnt_r != 16'hFFFF)) begin
      tmo_cnt_r <= tmo_cnt_r + 16'd1;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_s     = state_r;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    load_ir     = 1'b0;
    load_pc     = 1'b0;
    sel_pc      = PC_SEQ;
    load_abc    = 1'b0;
    sel_a_imm   = 1'b0;
    alu_go      = 1'b0;
    load_status = 1'b0;
    rf_we       = 1'b0;
    sel_wb      = WB_ALU;
    halted      = 1'b0;
    fault       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_FETCH;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          load_ir = 1'b1;
          load_pc = 1'b1;
          sel_pc  = PC_SEQ;
          state_s = S_DECODE;
        end else if (tmo_hit_s) begin
          state_s = S_FAULT;
        end else begin
          state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        load_abc = 1'b1;
        // A failed condition skips the instruction with no further side effects.
        if (!cond_pass_s) begin
          state_s = S_FETCH;
        end else if ((opcode == OP_HALT) && (iclass == CLS_DATA)) begin
          state_s = S_HALT;
        end else begin
          state_s = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_go = 1'b1;
        case (iclass)
          CLS_DATA: begin
            // opcode[3] marks the immediate-operand ALU class.
            sel_a_imm   = opcode[3];
            load_status = en_status;
            if (opcode[2:0] == ALU_CMP) begin
              state_s = S_FETCH;
            end else begin
              state_s = S_WB;
            end
          end
          CLS_LDST: begin
            sel_a_imm = ~ldst_reg_s;
            state_s   = S_MEM;
          end
          CLS_BRANCH: begin
            state_s = S_FETCH;
            case (opcode)
              OP_B: begin
                load_pc = 1'b1;
                sel_pc  = PC_BRANCH;
              end
              OP_BL: begin
                load_pc = 1'b1;
                sel_pc  = PC_BRANCH;
                rf_we   = 1'b1;
                sel_wb  = WB_LINK;
              end
              OP_BX: begin
                load_pc = 1'b1;
                sel_pc  = PC_RM;
              end
              OP_BLX: begin
                load_pc = 1'b1;
                sel_pc  = PC_RM;
                rf_we   = 1'b1;
                sel_wb  = WB_LINK;
              end
              default: begin
                load_pc = 1'b0;
              end
            endcase
          end
          default: begin
            state_s = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = ~is_ldr_s;
        if (dmem_ready) begin
          if (is_ldr_s) begin
            state_s = S_WB;
          end else begin
            state_s = S_FETCH;
          end
        end else if (tmo_hit_s) begin
          state_s = S_FAULT;
        end else begin
          state_s = S_MEM;
        end
      end
      S_WB: begin
        rf_we = 1'b1;
        if (iclass == CLS_LDST) begin
          sel_wb = WB_MEM;
        end else begin
          sel_wb = WB_ALU;
        end
        state_s = S_FETCH;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_s = S_HALT;
      end
      S_FAULT: begin
        fault   = 1'b1;
        state_s = S_FAULT;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

`ifdef CPU_PERF_CNT_EN
  logic [31:0] cyc_cnt_r;
  logic [31:0] ret_cnt_r;
  logic        retire_s;

  // Any return to FETCH from the pipeline states retires one instruction.
  assign retire_s = (state_s == S_FETCH) &&
                    ((state_r == S_DECODE) || (state_r == S_EXEC) ||
                     (state_r == S_MEM)    || (state_r == S_WB));

  // Performance counters, free-running and wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_r <= 32'd0;
      ret_cnt_r <= 32'd0;
    end else begin
      if ((state_r != S_IDLE) && (state_r != S_HALT)) begin
        cyc_cnt_r <= cyc_cnt_r + 32'd1;
      end else begin
        cyc_cnt_r <= cyc_cnt_r;
      end
      if (retire_s) begin
        ret_cnt_r <= ret_cnt_r + 32'd1;
      end else begin
        ret_cnt_r <= ret_cnt_r;
      end
    end
  end

  assign cyc_cnt = cyc_cnt_r;
  assign ret_cnt = ret_cnt_r;
`endif

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: one linear sequence of instructions with the
// expected control-output vector for every cycle written out by hand.
module tb_cpu_controller;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  cond;
  logic [6:0]  opcode;
  logic [1:0]  iclass;
  logic        en_status;
  logic [3:0]  nzcv;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req, dmem_req, dmem_we, load_ir, load_pc, load_abc;
  logic        sel_a_imm, alu_go, load_status, rf_we, halted, fault;
  logic [1:0]  sel_pc, sel_wb;
`ifdef CPU_PERF_CNT_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Output vector layout:
  // [15] imem_req [14] dmem_req [13] dmem_we [12] load_ir [11] load_pc [10:9] sel_pc
  // [8] load_abc [7] sel_a_imm [6] alu_go [5] load_status [4] rf_we [3:2] sel_wb
  // [1] halted [0] fault
  logic [15:0] outs;
  assign outs = {imem_req, dmem_req, dmem_we, load_ir, load_pc, sel_pc, load_abc,
                 sel_a_imm, alu_go, load_status, rf_we, sel_wb, halted, fault};

  localparam logic [15:0] O_IREQ    = 16'h8000;
  localparam logic [15:0] O_DREQ    = 16'h4000;
  localparam logic [15:0] O_DWE     = 16'h2000;
  localparam logic [15:0] O_LIR     = 16'h1000;
  localparam logic [15:0] O_LPC     = 16'h0800;
  localparam logic [15:0] O_PC_BR   = 16'h0200;
  localparam logic [15:0] O_PC_RM   = 16'h0400;
  localparam logic [15:0] O_ABC     = 16'h0100;
  localparam logic [15:0] O_AIMM    = 16'h0080;
  localparam logic [15:0] O_ALU     = 16'h0040;
  localparam logic [15:0] O_LST     = 16'h0020;
  localparam logic [15:0] O_RFWE    = 16'h0010;
  localparam logic [15:0] O_WB_MEM  = 16'h0004;
  localparam logic [15:0] O_WB_LINK = 16'h0008;
  localparam logic [15:0] O_HALT    = 16'h0002;
  localparam logic [15:0] O_FAULT   = 16'h0001;
  localparam logic [15:0] O_NONE    = 16'h0000;
  localparam logic [15:0] F_OK      = O_IREQ | O_LIR | O_LPC;

  // {cond, nzcv, expected pass}
  logic [8:0] cond_tab [7] = '{
    {4'b1111, 4'b0000, 1'b0},   // never
    {4'b1000, 4'b0010, 1'b1},   // HI: C=1 Z=0
    {4'b1001, 4'b0010, 1'b0},   // LS: C=1 Z=0
    {4'b1010, 4'b1001, 1'b1},   // GE: N=V=1
    {4'b1011, 4'b1001, 1'b0},   // LT: N=V=1
    {4'b1100, 4'b0100, 1'b0},   // GT: Z=1
    {4'b1101, 4'b0100, 1'b1}    // LE: Z=1
  };

  cpu_controller #(.MEM_TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cond        (cond),
    .opcode      (opcode),
    .iclass      (iclass),
    .en_status   (en_status),
    .nzcv        (nzcv),
    .imem_ready  (imem_ready),
    .dmem_ready  (dmem_ready),
    .imem_req    (imem_req),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .load_ir     (load_ir),
    .load_pc     (load_pc),
    .sel_pc      (sel_pc),
    .load_abc    (load_abc),
    .sel_a_imm   (sel_a_imm),
    .alu_go      (alu_go),
    .load_status (load_status),
    .rf_we       (rf_we),
    .sel_wb      (sel_wb),
    .halted      (halted),
    .fault       (fault)
`ifdef CPU_PERF_CNT_EN
    ,
    .cyc_cnt     (cyc_cnt),
    .ret_cnt     (ret_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] exp);
    n_chk++;
    assert (outs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, outs, exp);
    end
  endtask

  // Inputs already applied; settle, compare, then advance to just after the next edge.
  task automatic cyc(input string tag, input logic [15:0] exp);
    #1;
    chk(tag, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [3:0] c, input logic [6:0] op, input logic [1:0] cls,
                       input logic s);
    cond      = c;
    opcode    = op;
    iclass    = cls;
    en_status = s;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk("reset", O_NONE);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; nzcv = 4'b0000;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    instr(4'b0000, 7'b0000000, 2'b00, 1'b0);
    #2;
    chk("reset_at_t0", O_NONE);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // IDLE, then ADD imm cond=AL with zero-wait memory
    cyc("idle", O_NONE);
    start = 1'b1;
    cyc("idle_start", O_NONE);
    start = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    instr(4'b1110, 7'b0001100, 2'b00, 1'b0);
    cyc("add_c1_fetch", F_OK);
    cyc("add_c2_decode", O_ABC);
    cyc("add_c3_exec", O_ALU | O_AIMM);
    cyc("add_c4_wb", O_RFWE);

    // CMP with S=1: flags written, no register write
    instr(4'b1110, 7'b0000010, 2'b00, 1'b1);
    cyc("cmp_fetch", F_OK);
    cyc("cmp_decode", O_ABC);
    cyc("cmp_exec", O_ALU | O_LST);

    // BEQ with Z=1 is taken
    instr(4'b0000, 7'b1000000, 2'b10, 1'b0);
    nzcv = 4'b0100;
    cyc("beq_t_fetch", F_OK);
    cyc("beq_t_decode", O_ABC);
    cyc("beq_t_exec", O_ALU | O_LPC | O_PC_BR);

    // BEQ with Z=0 is skipped after DECODE
    nzcv = 4'b0000;
    cyc("beq_n_fetch", F_OK);
    cyc("beq_n_decode", O_ABC);

    // LDR imm with dmem_ready held off for 3 cycles
    instr(4'b1110, 7'b1100000, 2'b01, 1'b0);
    dmem_ready = 1'b0;
    cyc("ldr_fetch", F_OK);
    cyc("ldr_decode", O_ABC);
    cyc("ldr_exec", O_ALU | O_AIMM);
    cyc("ldr_mem1", O_DREQ);
    cyc("ldr_mem2", O_DREQ);
    cyc("ldr_mem3", O_DREQ);
    dmem_ready = 1'b1;
    cyc("ldr_mem4", O_DREQ);
    dmem_ready = 1'b0;
    cyc("ldr_wb", O_RFWE | O_WB_MEM);

    // STR register-offset: no immediate operand, write strobe with request
    instr(4'b1110, 7'b1111000, 2'b01, 1'b0);
    dmem_ready = 1'b1;
    cyc("str_fetch", F_OK);
    cyc("str_decode", O_ABC);
    cyc("str_exec", O_ALU);
    cyc("str_mem", O_DREQ | O_DWE);

    // BL, BX, BLX
    instr(4'b1110, 7'b1000001, 2'b10, 1'b0);
    cyc("bl_fetch", F_OK);
    cyc("bl_decode", O_ABC);
    cyc("bl_exec", O_ALU | O_LPC | O_PC_BR | O_RFWE | O_WB_LINK);
    instr(4'b1110, 7'b1000010, 2'b10, 1'b0);
    cyc("bx_fetch", F_OK);
    cyc("bx_decode", O_ABC);
    cyc("bx_exec", O_ALU | O_LPC | O_PC_RM);
    instr(4'b1110, 7'b1000011, 2'b10, 1'b0);
    cyc("blx_fetch", F_OK);
    cyc("blx_decode", O_ABC);
    cyc("blx_exec", O_ALU | O_LPC | O_PC_RM | O_RFWE | O_WB_LINK);

    // Condition-code table driven through a B instruction
    for (int i = 0; i < 7; i++) begin
      instr(cond_tab[i][8:5], 7'b1000000, 2'b10, 1'b0);
      nzcv = cond_tab[i][4:1];
      cyc($sformatf("cc%0d_fetch", i), F_OK);
      cyc($sformatf("cc%0d_decode", i), O_ABC);
      if (cond_tab[i][0]) begin
        cyc($sformatf("cc%0d_exec", i), O_ALU | O_LPC | O_PC_BR);
      end
    end

    // HALT: terminal, no further fetch even with imem_ready high
    instr(4'b1110, 7'b0000001, 2'b00, 1'b0);
    nzcv = 4'b0000;
    cyc("halt_fetch", F_OK);
    cyc("halt_decode", O_ABC);
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc($sformatf("halted_%0d", i), O_HALT);
    end
    start = 1'b0;

    // Instruction memory never ready: 16 wait cycles then FAULT
    do_reset();
    imem_ready = 1'b0;
    start = 1'b1;
    cyc("tmo_idle", O_NONE);
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc($sformatf("tmo_wait_%0d", i), O_IREQ);
    end
    cyc("tmo_fault", O_FAULT);
    imem_ready = 1'b1;
    cyc("tmo_fault_hold", O_FAULT);

    // Reset while a store is waiting in MEM drops the request at once
    do_reset();
    start = 1'b1;
    cyc("mr_idle", O_NONE);
    start = 1'b0;
    dmem_ready = 1'b0;
    instr(4'b1110, 7'b1110000, 2'b01, 1'b0);
    cyc("mr_fetch", F_OK);
    cyc("mr_decode", O_ABC);
    cyc("mr_exec", O_ALU | O_AIMM);
    #1;
    chk("mr_mem", O_DREQ | O_DWE);
    rst_n = 1'b0;
    #1;
    chk("mr_reset_drop", O_NONE);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc("mr_after_reset_idle", O_NONE);
    start = 1'b1;
    cyc("mr_restart_idle", O_NONE);
    start = 1'b0;
    cyc("mr_restart_fetch", F_OK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
